fadd_accum: RTL and testbench

//  Streaming IEEE-754 single-precision accumulator wrapped around the combinational faddV adder.

---
 rtl/fadd_accum_pkg.sv | 26 ++
 rtl/fadd_accum_fadd.sv | 73 +++++++
 rtl/fadd_accum.sv | 97 +++++++++
 tb/tb_fadd_accum.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fadd_accum_pkg.sv
// Shared definitions for the streaming single-precision accumulator.
// Holds the FSM state type, FP constants and field helpers.
package fadd_accum_pkg;

  localparam int unsigned FP_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_1P5  = 32'h3FC0_0000;
  localparam logic [31:0] FP_4P5  = 32'h4090_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  function automatic logic fp_is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != '0);
  endfunction

  function automatic logic fp_is_inf(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] == '0);
  endfunction

endpackage

// File: rtl/fadd_accum_fadd.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even,
// with subnormal support; any NaN operand or inf-inf yields a quiet NaN.
module faddV
  import fadd_accum_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic        swap, sub, up;
  logic [31:0] big, sml;
  logic [7:0]  e_big, e_sml, d;
  logic [23:0] m_big, m_sml;
  logic [53:0] sh;
  logic [26:0] al, norm;
  logic [27:0] sum;
  logic [9:0]  e;
  logic [24:0] mt;

  always_comb begin
    swap  = b[30:0] > a[30:0];
    big   = swap ? b : a;
    sml   = swap ? a : b;
    e_big = (big[30:23] == 8'h00) ? 8'd1 : big[30:23];
    e_sml = (sml[30:23] == 8'h00) ? 8'd1 : sml[30:23];
    m_big = {big[30:23] != 8'h00, big[22:0]};
    m_sml = {sml[30:23] != 8'h00, sml[22:0]};
    d     = e_big - e_sml;
    sub   = big[31] ^ sml[31];

    // Align the smaller operand keeping guard/round plus a sticky OR of everything shifted out.
    sh = {m_sml, 3'b000, 27'b0} >> d;
    if (d >= 8'd27) al = {26'b0, |m_sml};
    else            al = {sh[53:28], sh[27] | (|sh[26:0])};

    sum = sub ? ({1'b0, m_big, 3'b000} - {1'b0, al})
              : ({1'b0, m_big, 3'b000} + {1'b0, al});

    e    = {2'b00, e_big};
    norm = sum[26:0];
    if (sum[27]) begin
      norm = {sum[27:2], sum[1] | sum[0]};
      e    = e + 10'd1;
    end else begin
      for (int unsigned i = 0; i < 26; i++) begin
        if (!norm[26] && (e > 10'd1)) begin
          norm = norm << 1;
          e    = e - 10'd1;
        end
      end
    end

    up = norm[2] & (norm[3] | norm[1] | norm[0]);
    mt = {1'b0, norm[26:3]} + 25'(up);
    if (mt[24]) begin
      mt = mt >> 1;
      e  = e + 10'd1;
    end

    if (fp_is_nan(a) || fp_is_nan(b) || (fp_is_inf(a) && fp_is_inf(b) && sub))
      y = FP_QNAN;
    else if (fp_is_inf(a) || fp_is_inf(b))
      y = {big[31], 8'hFF, 23'b0};
    else if (sum == '0)
      y = {a[31] & b[31], 31'b0};
    else if (e >= 10'd255)
      y = {big[31], 8'hFF, 23'b0};
    else
      y = {big[31], mt[23] ? e[7:0] : 8'h00, mt[22:0]};
  end

endmodule

// File: rtl/fadd_accum.sv
// Streaming single-precision accumulator: folds each in_last-terminated burst
// into one sum, presented with a saturating operand count on a valid/ready port.
module fadd_accum
  import fadd_accum_pkg::*;
#(
  parameter int unsigned FP_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  state_e            state_q, state_d;
  logic [FP_W-1:0]   acc_q, acc_d, add_y;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              accept;

  faddV u_fadd (
    .a (acc_q),
    .b (in_data),
    .y (add_y)
  );

  always_comb begin
    accept  = in_valid && in_ready_q;
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        // First sample loads directly so a lone -0.0 or NaN payload survives bit-exact.
        if (accept) begin
          acc_d   = in_data;
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = in_last ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          acc_d = add_y;
          if (cnt_q == '1) ovf_d = 1'b1;
          else             cnt_d = cnt_q + CNT_W'(1);
          if (in_last) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d != ST_HOLD);
    out_valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_fadd_accum.sv
// Scoreboard bench: two accumulators (16-bit and 2-bit counters) share one stimulus stream;
// expected results come from a real-arithmetic reference with explicit single-precision rounding.
module tb_fadd_accum;
  import fadd_accum_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid, out_ovf;
  logic        in_ready2, out_valid2, out_ovf2;
  logic [31:0] out_sum, out_sum2;
  logic [15:0] out_count;
  logic [1:0]  out_count2;

  int unsigned total = 0, bad = 0;
  bit          rand_ready = 1'b0;

  typedef struct packed {
    logic [31:0] sum;
    logic [15:0] c16;
    logic        o16;
    logic [1:0]  c2;
    logic        o2;
  } exp_t;
  exp_t sb[$];

  int unsigned m_n = 0;
  logic [31:0] m_acc = '0;
  bit          use_fixed = 1'b0;
  logic [31:0] fixed_sum = '0;

  fadd_accum #(.FP_W(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf));

  fadd_accum #(.FP_W(32), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
    .out_sum(out_sum2), .out_count(out_count2), .out_ovf(out_ovf2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic real f2r(input logic [31:0] v);
    int  ex;
    real mag;
    if (v[30:0] == '0) return 0.0;
    ex  = int'(v[30:23]);
    mag = (1.0 + real'(int'(v[22:0])) / 8388608.0) * (2.0 ** (ex - 127));
    return v[31] ? -mag : mag;
  endfunction

  // Round a real (exact sum of two normal singles) to nearest-even single.
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] dbits;
    logic [51:0] m;
    logic [24:0] mt;
    logic        up;
    int          se;
    if (r == 0.0) return 32'h0;
    dbits = $realtobits(r);
    m     = dbits[51:0];
    se    = int'(dbits[62:52]) - 1023 + 127;
    up    = m[28] & ((|m[27:0]) | m[29]);
    mt    = {2'b01, m[51:29]} + 25'(up);
    if (mt[24]) begin
      se++;
      mt = mt >> 1;
    end
    return {dbits[63], se[7:0], mt[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  ex;
    logic [22:0] fr;
    ex = 8'($urandom_range(120, 134));
    fr = 23'($urandom);
    return {1'($urandom_range(0, 1)), ex, fr};
  endfunction

  function automatic void model_accept(input logic [31:0] d, input logic l);
    exp_t e;
    if (m_n == 0) m_acc = d;
    else          m_acc = r2f(f2r(m_acc) + f2r(d));
    m_n++;
    if (l) begin
      e.sum = use_fixed ? fixed_sum : m_acc;
      e.c16 = (m_n > 65535) ? 16'hFFFF : 16'(m_n);
      e.o16 = (m_n > 65535);
      e.c2  = (m_n > 3) ? 2'd3 : 2'(m_n);
      e.o2  = (m_n > 3);
      sb.push_back(e);
      m_n = 0;
    end
  endfunction

  // Called on a falling edge; returns on the falling edge after the accepting rise.
  task automatic send(input logic [31:0] d, input logic l);
    int unsigned n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    model_accept(d, l);
    in_valid = 1'b0;
    if (l) begin
      chk("last_to_valid", out_valid, 1);
      chk("last_to_valid2", out_valid2, 1);
    end
  endtask

  task automatic burst(input int unsigned n, input logic [31:0] o0, o1, o2, o3, o4,
                       input logic [31:0] exp_sum);
    logic [31:0] ops [5];
    ops = '{o0, o1, o2, o3, o4};
    use_fixed = 1'b1;
    fixed_sum = exp_sum;
    for (int unsigned i = 0; i < n; i++) send(ops[i], i == n - 1);
    use_fixed = 1'b0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_out_valid2", out_valid2, 0);
    chk("rst_in_ready2", in_ready2, 1);
    sb.delete();
    m_n = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (out_valid) begin
        chk("out_valid2", out_valid2, 1);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_in_ready2", in_ready2, 0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: out_sum=%h presented, none required", out_sum);
        end else begin
          chk("out_sum", out_sum, sb[0].sum);
          chk("out_count", out_count, sb[0].c16);
          chk("out_ovf", out_ovf, sb[0].o16);
          chk("out_sum2", out_sum2, sb[0].sum);
          chk("out_count2", out_count2, sb[0].c2);
          chk("out_ovf2", out_ovf2, sb[0].o2);
          if (out_ready) void'(sb.pop_front());
        end
      end else if (out_valid2) begin
        total++;
        bad++;
        $display("FAIL valid2_alone: out_valid2=1 required 0");
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned len, gap, n;
    do_reset();
    @(negedge clk);
    out_ready = 1'b1;

    burst(2, FP_1P5, FP_4P5, 0, 0, 0, 32'h40C00000);
    burst(3, FP_1P5, FP_4P5, 32'h40C00000, 0, 0, 32'h41400000);
    burst(1, 32'h3AA137F4, 0, 0, 0, 0, 32'h3AA137F4);
    burst(2, 32'hBFBCCCCD, 32'h3AA137F4, 0, 0, 0, 32'hBFBCA47F);
    @(negedge clk);

    // Result held with out_ready low; next burst's operand waits at the input meanwhile.
    out_ready = 1'b0;
    burst(2, FP_1P5, FP_4P5, 0, 0, 0, 32'h40C00000);
    fork
      burst(1, 32'h40C00000, 0, 0, 0, 0, 32'h40C00000);
      begin
        repeat (3) @(negedge clk);
        chk("t5_still_valid", out_valid, 1);
        chk("t5_held_sum", out_sum, 32'h40C00000);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);

    send(FP_1P5, 1'b0);
    send(FP_4P5, 1'b0);
    do_reset();
    burst(2, FP_1P5, FP_4P5, 0, 0, 0, 32'h40C00000);
    @(negedge clk);

    out_ready = 1'b0;
    burst(2, FP_4P5, FP_4P5, 0, 0, 0, 32'h41100000);
    do_reset();
    out_ready = 1'b1;

    burst(5, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
          32'h40A00000);
    @(negedge clk);

    rand_ready = 1'b1;
    for (int unsigned b = 0; b < 40; b++) begin
      len = $urandom_range(1, 8);
      for (int unsigned i = 0; i < len; i++) begin
        send(rand_fp(), i == len - 1);
        gap = $urandom_range(0, 2);
        repeat (gap) @(negedge clk);
      end
    end
    rand_ready = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
